i8254_write_control_unit: RTL and testbench
===========================================

Name: i8254_write_control_unit

Overview:
Upstream bus-write stage of the 8254 timer. It samples the CPU write interface, decodes control words into per-counter mode, BCD and read/write format, and steers count bytes into three 16-bit count registers. It issues per-counter load pulses to the downstream mode blocks (Mode 0..5) once a count is complete.

Parameters:
NUM_COUNTERS, 3, counters served; fixed at 3, counter n uses slice n of every per-counter vector.

Ports:
CLK  input  1  system clock; all logic on rising edge
RST_N  input  1  synchronous reset, active-low
CS_N  input  1  chip select, active-low
WR_N  input  1  write strobe, active-low, synchronous to CLK
A  input  2  address: 00/01/10 = counter 0/1/2 count, 11 = control word
DIN  input  8  write data
MODE  output  9  counter n mode at [3n+2:3n]
BCD  output  3  counter n BCD flag
RW_MODE  output  6  counter n RW field at [2n+1:2n]; 00 = unprogrammed
COUNT_REG0  output  16  assembled count, counter 0
COUNT_REG1  output  16  assembled count, counter 1
COUNT_REG2  output  16  assembled count, counter 2
COUNT_LOAD  output  3  1-cycle pulse: count register n complete
CW_LOAD  output  3  1-cycle pulse: control word accepted for counter n
LATCH_CMD  output  3  1-cycle pulse: counter-latch command for counter n
MSB_PENDING  output  3  counter n awaiting MSB of a two-byte count
ILLEGAL_WR  output  1  1-cycle pulse: write ignored

Behaviour:
- Reset: when RST_N=0 at a CLK edge, every register and output clears to 0: MODE, BCD, RW_MODE, COUNT_REGn, pointers, and all pulses. Reset mid two-byte sequence discards the pending LSB.
- Sampling: each cycle register wr_q<=WR_N. While WR_N=0, also capture cs_q<=CS_N, a_q<=A, d_q<=DIN. Reset value of wr_q is 1.
- Write event: occurs at the edge where wr_q=0, WR_N=1 and cs_q=0, i.e. on the trailing edge of the strobe. Results are visible after that edge, so latency is 1 cycle from WR_N rising.
- Timing: WR_N must be low for at least 1 cycle and high for at least 1 cycle between writes. A strobe with cs_q=1 produces no event.
- Pulses (COUNT_LOAD, CW_LOAD, LATCH_CMD, ILLEGAL_WR) are high for exactly the one cycle following the event and 0 otherwise.
- Control word (a_q=11) decodes d_q as SC=[7:6], RW=[5:4], M=[3:1], BCD=[0]:
  - SC=11 (read-back, not supported): ILLEGAL_WR pulse; no state change.
  - RW=00: LATCH_CMD[SC] pulse; MODE, BCD, RW_MODE and pointer unchanged.
  - Otherwise: MODE[SC]<=M, normalised so 110->010 and 111->011. Also BCD[SC]<=d_q[0], RW_MODE[SC]<=RW, MSB_PENDING[SC]<=0, CW_LOAD[SC] pulse. COUNT_REG[SC] is unchanged.
- Count byte (a_q=n, n in 0..2), by RW_MODE[n]:
  - 00: ILLEGAL_WR pulse; ignored.
  - 01: COUNT_REGn<={8'h00,d_q}; COUNT_LOAD[n] pulse.
  - 10: COUNT_REGn<={d_q,8'h00}; COUNT_LOAD[n] pulse.
  - 11, MSB_PENDING[n]=0: COUNT_REGn[7:0]<=d_q; MSB_PENDING[n]<=1; no load pulse.
  - 11, MSB_PENDING[n]=1: COUNT_REGn[15:8]<=d_q; MSB_PENDING[n]<=0; COUNT_LOAD[n] pulse.
- Independence: a control word to counter n clears only pointer n. A pending MSB on other counters survives interleaved writes to them.
- Count of 0: a count of 0000 is stored and loaded as-is. Downstream blocks interpret 0 as the maximum count.
- Simultaneous events: at most one write event per cycle, so there are no simultaneous events. RST_N=0 overrides a coincident write event.

Test Plan:
1. Reset then write CW 8'h30, then count bytes 8'h34 and 8'h12 to A=00. Required: CW_LOAD=001 and MODE[2:0]=000. After the first byte, MSB_PENDING[0]=1 with no load. After the second, COUNT_REG0=16'h1234 and COUNT_LOAD=001 for exactly 1 cycle.
2. CW 8'h5E (counter 1, LSB only, mode 7, binary), then byte 8'hAA to A=01. Required: MODE[5:3]=011 and COUNT_REG1=16'h00AA with COUNT_LOAD=010. A second CW 8'h60 (MSB only), then 8'h55, gives COUNT_REG1=16'h5500.
3. Count byte to A=10 before any CW, then CW 8'hC0. Required: ILLEGAL_WR pulses twice; all state is unchanged.
4. CW 8'hB0 to counter 2, LSB 8'h11, then CW 8'h80 (latch), then MSB 8'h22. Required: LATCH_CMD=100, MSB_PENDING[2] stays 1 through the latch, and COUNT_REG2=16'h2211 at the end. Separately, CW 8'hB0 between the LSB and MSB clears MSB_PENDING[2], so the next byte is taken as LSB.
5. Strobe with CS_N=1, and a strobe with RST_N pulsed low after the LSB of a two-byte count. Required: the first gives no event. The second gives all outputs 0, MSB_PENDING=000 and RW_MODE=000.

Source files
------------

// File: rtl/i8254_write_control_unit_if.sv
// CPU write bus of the 8254: chip select, write strobe, address and data.
// The CPU side drives it (master); the write control unit samples it (slave).
interface i8254_write_control_unit_if;
  logic       CS_N;
  logic       WR_N;
  logic [1:0] A;
  logic [7:0] DIN;

  modport master (output CS_N, WR_N, A, DIN);
  modport slave  (input  CS_N, WR_N, A, DIN);
endinterface

// File: rtl/i8254_write_control_unit.sv
// 8254 bus-write stage: samples the CPU write strobe and acts on its trailing edge.
// It decodes control words per counter, assembles count bytes, and emits one-cycle load pulses.
module i8254_write_control_unit #(
  parameter int NUM_COUNTERS = 3
) (
  input  logic                        CLK,
  input  logic                        RST_N,
  i8254_write_control_unit_if.slave   bus,
  output logic [3*NUM_COUNTERS-1:0]   MODE,
  output logic [NUM_COUNTERS-1:0]     BCD,
  output logic [2*NUM_COUNTERS-1:0]   RW_MODE,
  output logic [15:0]                 COUNT_REG0,
  output logic [15:0]                 COUNT_REG1,
  output logic [15:0]                 COUNT_REG2,
  output logic [NUM_COUNTERS-1:0]     COUNT_LOAD,
  output logic [NUM_COUNTERS-1:0]     CW_LOAD,
  output logic [NUM_COUNTERS-1:0]     LATCH_CMD,
  output logic [NUM_COUNTERS-1:0]     MSB_PENDING,
  output logic                        ILLEGAL_WR
);

  logic       wr_q;
  logic       cs_q;
  logic [1:0] a_q;
  logic [7:0] d_q;
  logic       wr_event;

  logic [15:0] count_q [NUM_COUNTERS];
  logic [15:0] count_n [NUM_COUNTERS];

  logic [3*NUM_COUNTERS-1:0] mode_n;
  logic [NUM_COUNTERS-1:0]   bcd_n;
  logic [2*NUM_COUNTERS-1:0] rw_n;
  logic [NUM_COUNTERS-1:0]   pend_n;
  logic [NUM_COUNTERS-1:0]   count_load_n;
  logic [NUM_COUNTERS-1:0]   cw_load_n;
  logic [NUM_COUNTERS-1:0]   latch_n;
  logic                      illegal_n;

  logic [1:0] sc;
  logic [1:0] rw;
  logic [2:0] m_norm;

  // The event fires when the strobe that was low is seen high again, so the
  // captured address/data are those present during the low phase.
  assign wr_event = !wr_q && bus.WR_N && !cs_q;

  assign sc     = d_q[7:6];
  assign rw     = d_q[5:4];
  assign m_norm = (d_q[3] && d_q[2]) ? {1'b0, d_q[2:1]} : d_q[3:1];

  assign COUNT_REG0 = count_q[0];
  assign COUNT_REG1 = count_q[1];
  assign COUNT_REG2 = count_q[2];

  always_comb begin
    mode_n       = MODE;
    bcd_n        = BCD;
    rw_n         = RW_MODE;
    pend_n       = MSB_PENDING;
    count_load_n = '0;
    cw_load_n    = '0;
    latch_n      = '0;
    illegal_n    = 1'b0;
    for (int n = 0; n < NUM_COUNTERS; n++) begin
      count_n[n] = count_q[n];
    end

    if (wr_event) begin
      if (a_q == 2'b11) begin
        if (sc == 2'b11) begin
          illegal_n = 1'b1;
        end else begin
          for (int n = 0; n < NUM_COUNTERS; n++) begin
            if (sc == 2'(n)) begin
              if (rw == 2'b00) begin
                latch_n[n] = 1'b1;
              end else begin
                mode_n[3*n +: 3] = m_norm;
                bcd_n[n]         = d_q[0];
                rw_n[2*n +: 2]   = rw;
                pend_n[n]        = 1'b0;
                cw_load_n[n]     = 1'b1;
              end
            end
          end
        end
      end else begin
        for (int n = 0; n < NUM_COUNTERS; n++) begin
          if (a_q == 2'(n)) begin
            case (RW_MODE[2*n +: 2])
              2'b00: illegal_n = 1'b1;
              2'b01: begin
                count_n[n]      = {8'h00, d_q};
                count_load_n[n] = 1'b1;
              end
              2'b10: begin
                count_n[n]      = {d_q, 8'h00};
                count_load_n[n] = 1'b1;
              end
              default: begin
                // Two-byte format: LSB first, MSB completes the count.
                if (!MSB_PENDING[n]) begin
                  count_n[n][7:0] = d_q;
                  pend_n[n]       = 1'b1;
                end else begin
                  count_n[n][15:8] = d_q;
                  pend_n[n]        = 1'b0;
                  count_load_n[n]  = 1'b1;
                end
              end
            endcase
          end
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      wr_q        <= 1'b1;
      cs_q        <= 1'b0;
      a_q         <= '0;
      d_q         <= '0;
      MODE        <= '0;
      BCD         <= '0;
      RW_MODE     <= '0;
      MSB_PENDING <= '0;
      COUNT_LOAD  <= '0;
      CW_LOAD     <= '0;
      LATCH_CMD   <= '0;
      ILLEGAL_WR  <= 1'b0;
      for (int n = 0; n < NUM_COUNTERS; n++) begin
        count_q[n] <= '0;
      end
    end else begin
      wr_q <= bus.WR_N;
      if (!bus.WR_N) begin
        cs_q <= bus.CS_N;
        a_q  <= bus.A;
        d_q  <= bus.DIN;
      end
      MODE        <= mode_n;
      BCD         <= bcd_n;
      RW_MODE     <= rw_n;
      MSB_PENDING <= pend_n;
      COUNT_LOAD  <= count_load_n;
      CW_LOAD     <= cw_load_n;
      LATCH_CMD   <= latch_n;
      ILLEGAL_WR  <= illegal_n;
      for (int n = 0; n < NUM_COUNTERS; n++) begin
        count_q[n] <= count_n[n];
      end
    end
  end

endmodule

// File: tb/tb_i8254_write_control_unit.sv
// Bench for i8254_write_control_unit: directed and random CPU writes against a reference model.
// Expected pulses are queued at issue time and matched by a monitor whenever the DUT pulses.
module tb_i8254_write_control_unit;

  logic clk;
  logic rst_n;

  logic [8:0]  MODE;
  logic [2:0]  BCD;
  logic [5:0]  RW_MODE;
  logic [15:0] COUNT_REG0, COUNT_REG1, COUNT_REG2;
  logic [2:0]  COUNT_LOAD, CW_LOAD, LATCH_CMD, MSB_PENDING;
  logic        ILLEGAL_WR;

  i8254_write_control_unit_if bus ();

  i8254_write_control_unit #(.NUM_COUNTERS(3)) dut (
    .CLK(clk),
    .RST_N(rst_n),
    .bus(bus),
    .MODE(MODE),
    .BCD(BCD),
    .RW_MODE(RW_MODE),
    .COUNT_REG0(COUNT_REG0),
    .COUNT_REG1(COUNT_REG1),
    .COUNT_REG2(COUNT_REG2),
    .COUNT_LOAD(COUNT_LOAD),
    .CW_LOAD(CW_LOAD),
    .LATCH_CMD(LATCH_CMD),
    .MSB_PENDING(MSB_PENDING),
    .ILLEGAL_WR(ILLEGAL_WR)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks_total  = 0;
  int checks_passed = 0;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks_total++;
    if (act === exp) checks_passed++;
    else $display("[TB] FAIL %s: got 0x%0h, required 0x%0h (time %0t)", name, act, exp, $time);
  endfunction

  // Reference model: per-counter programming kept as plain arrays.
  logic [2:0]  m_mode [3];
  logic        m_bcd  [3];
  logic [1:0]  m_rw   [3];
  logic [15:0] m_cnt  [3];
  logic        m_pend [3];

  typedef struct {
    int         cyc;
    logic [2:0] cl;
    logic [2:0] cw;
    logic [2:0] lt;
    logic       il;
  } exp_t;
  exp_t exp_q[$];

  task automatic modelReset();
    for (int i = 0; i < 3; i++) begin
      m_mode[i] = 3'd0; m_bcd[i] = 1'b0; m_rw[i] = 2'd0; m_cnt[i] = 16'd0; m_pend[i] = 1'b0;
    end
  endtask

  task automatic modelWrite(input logic [1:0] a, input logic [7:0] d, output exp_t e);
    int sc;
    int mm;
    e.cyc = 0; e.cl = '0; e.cw = '0; e.lt = '0; e.il = 1'b0;
    if (a == 2'd3) begin
      sc = int'(d[7:6]);
      if (sc == 3) e.il = 1'b1;
      else if (d[5:4] == 2'd0) e.lt[sc] = 1'b1;
      else begin
        mm = int'(d[3:1]);
        if (mm >= 6) mm = mm - 4;
        m_mode[sc] = 3'(mm);
        m_bcd[sc]  = d[0];
        m_rw[sc]   = d[5:4];
        m_pend[sc] = 1'b0;
        e.cw[sc]   = 1'b1;
      end
    end else begin
      case (m_rw[a])
        2'd0: e.il = 1'b1;
        2'd1: begin m_cnt[a] = 16'(d); e.cl[a] = 1'b1; end
        2'd2: begin m_cnt[a] = 16'(d) * 16'd256; e.cl[a] = 1'b1; end
        default: begin
          if (!m_pend[a]) begin
            m_cnt[a]  = (m_cnt[a] & 16'hFF00) | 16'(d);
            m_pend[a] = 1'b1;
          end else begin
            m_cnt[a]  = (m_cnt[a] & 16'h00FF) | (16'(d) * 16'd256);
            m_pend[a] = 1'b0;
            e.cl[a]   = 1'b1;
          end
        end
      endcase
    end
  endtask

  task automatic checkOutput(input string tag);
    check({tag, "_mode"},    32'(MODE),        32'({m_mode[2], m_mode[1], m_mode[0]}));
    check({tag, "_bcd"},     32'(BCD),         32'({m_bcd[2], m_bcd[1], m_bcd[0]}));
    check({tag, "_rw_mode"}, 32'(RW_MODE),     32'({m_rw[2], m_rw[1], m_rw[0]}));
    check({tag, "_count0"},  32'(COUNT_REG0),  32'(m_cnt[0]));
    check({tag, "_count1"},  32'(COUNT_REG1),  32'(m_cnt[1]));
    check({tag, "_count2"},  32'(COUNT_REG2),  32'(m_cnt[2]));
    check({tag, "_msb_pend"}, 32'(MSB_PENDING), 32'({m_pend[2], m_pend[1], m_pend[0]}));
  endtask

  // Monitor: every cycle with a pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    exp_t e;
    if (|COUNT_LOAD || |CW_LOAD || |LATCH_CMD || ILLEGAL_WR) begin
      if (exp_q.size() == 0) begin
        check("unexpected_pulse", {COUNT_LOAD, CW_LOAD, LATCH_CMD, ILLEGAL_WR}, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("pulse_cycle", 32'(cyc),        32'(e.cyc));
        check("count_load",  32'(COUNT_LOAD), 32'(e.cl));
        check("cw_load",     32'(CW_LOAD),    32'(e.cw));
        check("latch_cmd",   32'(LATCH_CMD),  32'(e.lt));
        check("illegal_wr",  32'(ILLEGAL_WR), 32'(e.il));
      end
    end
  end

  task automatic doReset();
    @(negedge clk);
    rst_n    = 1'b0;
    bus.WR_N = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    modelReset();
  endtask

  task automatic applyStimulus(input logic cs, input logic [1:0] a, input logic [7:0] d,
                               input int low_cycles, input int high_cycles, input string tag);
    exp_t e;
    @(negedge clk);
    bus.CS_N = cs;
    bus.A    = a;
    bus.DIN  = d;
    bus.WR_N = 1'b0;
    repeat (low_cycles - 1) @(negedge clk);
    @(negedge clk);
    bus.WR_N = 1'b1;
    bus.DIN  = 8'($urandom);
    bus.A    = 2'($urandom);
    if (!cs) begin
      modelWrite(a, d, e);
      e.cyc = cyc + 1;
      if (|e.cl || |e.cw || |e.lt || e.il) exp_q.push_back(e);
    end
    repeat (high_cycles) @(negedge clk);
    checkOutput(tag);
  endtask

  // Write whose trailing edge coincides with reset: reset must win.
  task automatic resetDuringEvent(input logic [1:0] a, input logic [7:0] d);
    @(negedge clk);
    bus.CS_N = 1'b0;
    bus.A    = a;
    bus.DIN  = d;
    bus.WR_N = 1'b0;
    @(negedge clk);
    bus.WR_N = 1'b1;
    rst_n    = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    modelReset();
    @(negedge clk);
    checkOutput("rst_event");
  endtask

  initial begin
    rst_n    = 1'b0;
    bus.CS_N = 1'b1;
    bus.WR_N = 1'b1;
    bus.A    = 2'd0;
    bus.DIN  = 8'd0;
    modelReset();
    doReset();
    checkOutput("reset");

    applyStimulus(1'b0, 2'd3, 8'h30, 1, 1, "tp1_cw");
    check("tp1_mode0", 32'(MODE[2:0]), 32'd0);
    applyStimulus(1'b0, 2'd0, 8'h34, 1, 1, "tp1_lsb");
    check("tp1_pend0", 32'(MSB_PENDING[0]), 32'd1);
    applyStimulus(1'b0, 2'd0, 8'h12, 2, 1, "tp1_msb");
    check("tp1_count0", 32'(COUNT_REG0), 32'h1234);

    applyStimulus(1'b0, 2'd3, 8'h5E, 1, 2, "tp2_cw");
    check("tp2_mode1", 32'(MODE[5:3]), 32'd3);
    applyStimulus(1'b0, 2'd1, 8'hAA, 1, 1, "tp2_lsb");
    check("tp2_count1", 32'(COUNT_REG1), 32'h00AA);
    applyStimulus(1'b0, 2'd3, 8'h60, 1, 1, "tp2_cw2");
    applyStimulus(1'b0, 2'd1, 8'h55, 3, 1, "tp2_msb");
    check("tp2_count1b", 32'(COUNT_REG1), 32'h5500);

    doReset();
    applyStimulus(1'b0, 2'd2, 8'h77, 1, 1, "tp3_byte");
    applyStimulus(1'b0, 2'd3, 8'hC0, 1, 1, "tp3_rdback");
    check("tp3_rw_mode", 32'(RW_MODE), 32'd0);

    applyStimulus(1'b0, 2'd3, 8'hB0, 1, 1, "tp4_cw");
    applyStimulus(1'b0, 2'd2, 8'h11, 1, 1, "tp4_lsb");
    applyStimulus(1'b0, 2'd3, 8'h80, 1, 1, "tp4_latch");
    check("tp4_pend2", 32'(MSB_PENDING[2]), 32'd1);
    applyStimulus(1'b0, 2'd2, 8'h22, 1, 1, "tp4_msb");
    check("tp4_count2", 32'(COUNT_REG2), 32'h2211);
    applyStimulus(1'b0, 2'd2, 8'h33, 1, 1, "tp4_lsb2");
    applyStimulus(1'b0, 2'd3, 8'hB0, 1, 1, "tp4_cw2");
    check("tp4_pend2_clr", 32'(MSB_PENDING[2]), 32'd0);
    applyStimulus(1'b0, 2'd2, 8'h44, 1, 1, "tp4_lsb3");
    check("tp4_count2b", 32'(COUNT_REG2), 32'h2244);
    check("tp4_pend2b", 32'(MSB_PENDING[2]), 32'd1);

    applyStimulus(1'b1, 2'd3, 8'h10, 1, 1, "tp5_nocs");
    applyStimulus(1'b0, 2'd3, 8'h30, 1, 1, "tp5_cw");
    applyStimulus(1'b0, 2'd0, 8'h99, 1, 1, "tp5_lsb");
    resetDuringEvent(2'd0, 8'h88);
    check("tp5_rw_mode", 32'(RW_MODE), 32'd0);
    check("tp5_pend", 32'(MSB_PENDING), 32'd0);

    for (int i = 0; i < 400; i++) begin
      logic       cs;
      logic [1:0] a;
      logic [7:0] d;
      if ($urandom_range(0, 59) == 0) doReset();
      cs = ($urandom_range(0, 9) == 0);
      a  = 2'($urandom_range(0, 3));
      d  = 8'($urandom);
      applyStimulus(cs, a, d, $urandom_range(1, 3), $urandom_range(1, 3), "rand");
    end

    repeat (4) @(negedge clk);
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
